// File: rtl/operand_fetch.sv
// operand_fetch: reads one or two source operands through a single register-file
// read port and presents them as a registered bundle with valid/ready handshakes.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : instruction handshake (in_ready is combinational)
//   in_op, in_rs1, in_rs2, in_rd  : opcode, source A, source B, destination
//   in_rs2_en                     : source B is required
//   rd_loc1 / rd_data1            : register-file read address / combinational data
//   wb_write, wb_loc, wb_data     : copy of the register-file write port (for bypass)
//   out_valid/out_ready           : bundle handshake
//   out_op, out_rd, out_a, out_b  : registered bundle
//   busy                          : not idle
module operand_fetch #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [3:0]        in_rd,
   input  logic              in_rs2_en,
   output logic [3:0]        rd_loc1,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic              wb_write,
   input  logic [3:0]        wb_loc,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_op,
   output logic [3:0]        out_rd,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, READ_A, READ_B, OUT} state_t;
   state_t state, state_n;
   logic [3:0] rs1_q, rs2_q;
   logic rs2_en_q, accept;
   logic [DATA_W-1:0] rd_val;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb
      state_n = accept              ? READ_A :
                state == READ_A     ? (rs2_en_q ? READ_B : OUT) :
                state == READ_B     ? OUT :
                (state == OUT && out_ready) ? IDLE : state;
   always_comb begin
      in_ready = !rst && (state == IDLE || (state == OUT && out_ready));
      rd_loc1  = state == READ_A ? rs1_q : state == READ_B ? rs2_q : 4'd0;
   end
   assign accept = in_valid && in_ready;
   // a write landing on the register being read this cycle wins over the stale array data
   assign rd_val = (wb_write && wb_loc == rd_loc1) ? wb_data : rd_data1;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_op    <= '0;
         out_rd    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rs2_en_q  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (accept) begin
            out_op   <= in_op;
            out_rd   <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            rs2_en_q <= in_rs2_en;
         end
         if (state == READ_A) begin
            out_a <= rd_val;
            if (!rs2_en_q) out_b <= '0;
         end
         if (state == READ_B) out_b <= rd_val;
         out_valid <= state_n == OUT;
         busy      <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed stimulus against a transaction-level model.
module tb_operand_fetch;
   localparam int W = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_rs2_en = 1'b0, wb_write = 1'b0, out_ready = 1'b0;
   logic [3:0] in_op = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_loc = '0;
   logic [W-1:0] wb_data = '0;
   logic in_ready, out_valid, busy;
   logic [3:0] rd_loc1, out_op, out_rd;
   logic [W-1:0] rd_data1, out_a, out_b;
   logic [W-1:0] regs [16];
   int tests = 0, fails = 0;

   operand_fetch #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs2_en(in_rs2_en), .rd_loc1(rd_loc1), .rd_data1(rd_data1),
      .wb_write(wb_write), .wb_loc(wb_loc), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .busy(busy)
   );

   always #5 clk = ~clk;
   assign rd_data1 = regs[rd_loc1];
   always @(posedge clk) if (wb_write) regs[wb_loc] <= wb_data;

   // model: one pending transaction, aged in cycles since its acceptance edge
   bit have = 0, live = 0;
   int age = 0;
   bit m_en;
   logic [3:0] m_op, m_rs1, m_rs2, m_rd;
   logic [W-1:0] m_a, m_b;
   logic [W-1:0] mreg [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      bit done, rdy, acc, was_rst;
      logic [3:0] addr;
      logic [W-1:0] v;
      done = have && age >= (m_en ? 3 : 2);
      rdy  = !rst && (!have || (done && out_ready));
      addr = (have && age == 1) ? m_rs1 : (have && age == 2 && m_en) ? m_rs2 : 4'd0;
      #1;
      chk("in_ready", in_ready, rdy);
      if (live) chk("rd_loc1", rd_loc1, addr);
      v = (wb_write && wb_loc == addr) ? wb_data : mreg[addr];
      acc = in_valid && rdy;
      was_rst = rst;
      @(posedge clk);
      live = 1;
      if (wb_write) mreg[wb_loc] = wb_data;
      if (rst) have = 0;
      else if (acc) begin
         have = 1; age = 1;
         m_op = in_op; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_en = in_rs2_en;
      end else if (done && out_ready) have = 0;
      else if (have && !done) begin
         if (age == 1) begin m_a = v; if (!m_en) m_b = '0; end
         if (age == 2) m_b = v;
         age++;
      end
      #1;
      done = have && age >= (m_en ? 3 : 2);
      chk("busy", busy, have);
      chk("out_valid", out_valid, done);
      if (done) begin
         chk("out_op", out_op, m_op);
         chk("out_rd", out_rd, m_rd);
         chk("out_a", out_a, m_a);
         chk("out_b", out_b, m_b);
      end
      if (was_rst) begin
         chk("rst_op", out_op, 0);
         chk("rst_rd", out_rd, 0);
         chk("rst_a", out_a, 0);
         chk("rst_b", out_b, 0);
      end
   endtask

   task automatic offer(input logic [3:0] op, rs1, rs2, input logic en, input logic [3:0] rd);
      in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rs2_en = en; in_rd = rd;
   endtask

   task automatic wb(input logic w, input logic [3:0] loc, input logic [W-1:0] d);
      wb_write = w; wb_loc = loc; wb_data = d;
   endtask

   initial begin
      // preload the register file while in reset
      for (int i = 0; i < 16; i++) begin
         wb(1, 4'(i), i == 3 ? 16'h1234 : i == 7 ? 16'hBEEF : i == 4 ? 16'h0042 : W'($urandom));
         step();
      end
      wb(0, 0, 0);
      rst = 0;
      chk("rst_busy", busy, 0);
      step();
      // basic fetch, rs2_en=1: valid on the third cycle after acceptance
      out_ready = 1;
      offer(2, 3, 7, 1, 5);
      step();
      in_valid = 0;
      step();
      chk("lat3_early", out_valid, 0);
      step();
      chk("lat3", out_valid, 1);
      chk("fetch_a", out_a, 16'h1234);
      chk("fetch_b", out_b, 16'hBEEF);
      chk("fetch_op", out_op, 2);
      chk("fetch_rd", out_rd, 5);
      step();
      chk("gap", out_valid, 0);
      // single source: no READ_B, valid at +2
      offer(1, 4, 9, 0, 6);
      step();
      in_valid = 0;
      step();
      chk("lat2", out_valid, 1);
      chk("single_a", out_a, 16'h0042);
      chk("single_b", out_b, 0);
      step();
      // bypass during READ_B
      offer(3, 3, 7, 1, 1);
      step();
      in_valid = 0;
      step();
      wb(1, 7, 16'h5555);
      step();
      wb(0, 0, 0);
      chk("bypass_b", out_b, 16'h5555);
      step();
      // restore R7, then a write one cycle after capture must not disturb out_b
      wb(1, 7, 16'hBEEF);
      step();
      wb(0, 0, 0);
      out_ready = 0;
      offer(3, 3, 7, 1, 1);
      step();
      in_valid = 0;
      step();
      step();
      wb(1, 7, 16'h5555);
      step();
      wb(0, 0, 0);
      chk("late_wb_b", out_b, 16'hBEEF);
      // backpressure: 5 held cycles with a competing instruction offered
      offer(9, 2, 3, 0, 4);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_op", out_op, 3);
         chk("bp_hold_b", out_b, 16'hBEEF);
      end
      out_ready = 1;
      step();
      in_valid = 0;
      chk("bp_accept", busy, 1);
      chk("bp_drop", out_valid, 0);
      step();
      chk("bp_next_op", out_op, 9);
      step();
      // reset while in READ_B abandons the transaction
      offer(5, 1, 2, 1, 3);
      step();
      in_valid = 0;
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rst_idle", busy, 0);
      for (int i = 0; i < 4; i++) step();
      // randomized traffic biased to low registers so bypasses happen often
      for (int i = 0; i < 800; i++) begin
         rst       = $urandom_range(0, 59) == 0;
         in_valid  = $urandom_range(0, 2) != 0;
         in_op     = 4'($urandom);
         in_rs1    = 4'($urandom_range(0, 3));
         in_rs2    = 4'($urandom_range(0, 3));
         in_rd     = 4'($urandom);
         in_rs2_en = 1'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         wb($urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)), W'($urandom));
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
